// File: rtl/uart_tx_sched_if.sv
// Bundle between the uart_tx_sched scheduler and its requesters/transmitter.
// Signals:
//   req_valid/req_data/req_last : per-requester byte stream (requester i on data[8i+7:8i])
//   req_ready                   : byte accepted this cycle (one-hot or zero)
//   grant                       : one-hot current packet owner, zero when idle
//   uart_data/uart_start        : byte and start pulse toward uart_tx
//   uart_done                   : completion strobe from uart_tx
//   busy/timeout_err            : status, watchdog abort pulse
// Modports: master = requester/transmitter side, slave = scheduler.
interface uart_tx_sched_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         uart_data;
  logic               uart_start;
  logic               uart_done;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req_valid, req_data, req_last, uart_done,
    input  req_ready, grant, uart_data, uart_start, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_done,
    output req_ready, grant, uart_data, uart_start, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one uart_tx among N_REQ requesters.
// A requester owns the transmitter from its first byte through the byte flagged last;
// each byte is loaded, started with a one-cycle pulse, then awaited via uart_done.
// A watchdog abandons the packet if done never arrives (TIMEOUT_CYCLES = 0 disables it).
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : uart_tx_sched_if.slave (requester streams, uart_tx handshake, status)
module uart_tx_sched #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input logic            clk,
  input logic            reset,
  uart_tx_sched_if.slave bus
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_last_owner;
  logic [N_REQ-1:0] r_grant;
  logic [7:0]       r_data;
  logic             r_start;
  logic             r_terr;
  logic             r_last;
  logic             r_first;
  logic [CW-1:0]    r_cnt;

  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [N_REQ-1:0] w_pick_oh;
  logic [IW-1:0]    w_cand;
  logic [7:0]       w_own_data;
  logic             w_own_last;
  logic             w_own_valid;

  // Round-robin search starting just after the previous owner, wrapping at N_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    w_cand    = r_last_owner;
    for (int unsigned o = 0; o < N_REQ; o++) begin
      w_cand = (w_cand == IW'(N_REQ - 1)) ? '0 : w_cand + IW'(1);
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!w_found && (w_cand == IW'(j)) && bus.req_valid[j]) begin
          w_found      = 1'b1;
          w_pick       = w_cand;
          w_pick_oh[j] = 1'b1;
        end
      end
    end
  end

  // Owner's byte and last flag.
  always_comb begin
    w_own_data = 8'h00;
    w_own_last = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_own_data = bus.req_data[8*i +: 8];
        w_own_last = bus.req_last[i];
      end
    end
  end

  assign w_own_valid = |(r_grant & bus.req_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IW'(N_REQ - 1);
      r_grant      <= '0;
      r_data       <= 8'h00;
      r_start      <= 1'b0;
      r_terr       <= 1'b0;
      r_last       <= 1'b0;
      r_first      <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_start <= 1'b0;
      r_terr  <= 1'b0;
      r_first <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_grant <= w_pick_oh;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Owner stalling mid-packet keeps the grant.
          if (w_own_valid) begin
            r_data  <= w_own_data;
            r_start <= 1'b1;
            r_last  <= w_own_last;
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The first WAIT cycle ignores done so a stale strobe is never taken;
          // done takes priority over a same-cycle watchdog expiry.
          if (!r_first && bus.uart_done) begin
            if (r_last) begin
              r_last_owner <= r_owner;
              r_grant      <= '0;
              r_state      <= ST_IDLE;
            end else begin
              r_state <= ST_SEND;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST)) begin
            r_terr       <= 1'b1;
            r_last_owner <= r_owner;
            r_grant      <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = (r_state == ST_SEND) ? (r_grant & bus.req_valid) : '0;
  assign bus.grant       = r_grant;
  assign bus.uart_data   = r_data;
  assign bus.uart_start  = r_start;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.timeout_err = r_terr;

endmodule
